aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Sequential AES-128 key schedule generating the 11 round keys (key 0 = cipher key, keys 1–10 derived) from a 128-bit cipher key and holding them in an internal key store. It sits directly upstream of the round-key selection mux: the AES round controller reads one stored key per round through a select port. Expansion runs once per Start and takes a fixed number of cycles.

## Interface
- No parameters. Widths and round counts are fixed by package constants.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  request expansion; sampled only in IDLE.
- Key_In  in  128  cipher key; sampled on the accepting edge only. w0 = Key_In[127:96].
- Rd_Sel  in  4  round-key index to read, 0–10.
- Rd_Key  out  128  combinational read of store[Rd_Sel]; 128'h0 for Rd_Sel 11–15.
- Busy  out  1  high while expanding.
- Done  out  1  one-cycle pulse when key 10 is available.
- Keys_Valid  out  1  high while the store holds a complete schedule for the last accepted key.

## Operation
- States: IDLE, EXPAND, FINISH.
- IDLE with Start=1:
  - store[0] <= Key_In; round counter <= 1; Keys_Valid <= 0; go to EXPAND.
- EXPAND, one round per step: store[r] <= next(store[r-1], RCON[r]), where next is the standard schedule:
  - t = SubWord(RotWord(w3)) ^ {RCON[r], 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- After store[10] is written: go to FINISH. FINISH lasts one cycle: Done=1, Keys_Valid=1, then IDLE.
- Start in EXPAND or FINISH is ignored and is not queued.
- Rd_Key is valid for key r once store[r] is written. Reading during expansion is allowed; unwritten entries return stale data.
- Keys_Valid stays high in IDLE until the next accepted Start.
- Reset, including mid-expansion: state IDLE, counter 0, all store entries 0, Busy=0, Done=0, Keys_Valid=0.

## Timing
- Reset values: Busy 0, Done 0, Keys_Valid 0. Rd_Key = 0 for any Rd_Sel.
- Start high in cycle 0, accepted at the end of cycle 0:
  - Busy high in cycles 1–10.
  - store[r] readable from cycle r+1.
  - Done and Keys_Valid high in cycle 11. Busy is 0 in cycle 11.
- Back-to-back: Start held high continuously re-triggers in cycle 12 at the earliest (first IDLE cycle).
- Rd_Key is purely combinational from Rd_Sel and the store. There is no read latency.

## Configuration
- KEYEXP_SERIAL_SBOX_EN defined:
  - One S-box instance, time-multiplexed.
  - Each round takes 4 cycles: bytes of RotWord(w3) are substituted one per cycle into a 32-bit holding register; the store is written in the 4th cycle.
  - Busy spans cycles 1–40; Done in cycle 41; store[r] readable from cycle 4r+1.
  - All other behaviour is unchanged.
- Undefined (default): four parallel S-box instances, one round per cycle, timing as above.

## Structure
- Shared package aes_pkg:
  - typedefs aes_word_t (32 bit) and aes_key_t (128 bit);
  - constants NUM_ROUNDS=10 and NUM_KEYS=11;
  - RCON constant array;
  - S-box constant table (256×8).
- The same package is reused by the cipher-round datapath.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational lookup from the package table. Instantiated 4× by default, 1× under KEYEXP_SERIAL_SBOX_EN.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, Start for 1 cycle:
  - Done pulses exactly in cycle 11 (cycle 41 in serial mode);
  - Rd_Sel=1 gives a0fafe1788542cb123a339392a6c7605;
  - Rd_Sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
  - Rd_Sel=0 returns the input key.
- Rd_Sel sweep 0–15 after Done: entries 11–15 read 0. Entries 0–10 match the reference schedule for all-zero and all-FF keys.
- Start pulsed again in cycle 5 with a different key: ignored; the final schedule matches the first key only.
- Reset asserted asynchronously in cycle 6: Busy, Done and Keys_Valid drop immediately; all reads return 0. A new Start afterwards completes normally.
- Start held high for 30 cycles:
  - expansions begin in cycles 0 and 12 (serial mode: 0 and 42);
  - Keys_Valid is 0 between acceptance and Done;
  - Done is a single-cycle pulse each time.
- Rd_Key read during expansion: store[3] is stable from cycle 4 onward and does not change afterwards.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, schedule constants and S-box table
// Used by the key expander and the cipher-round datapath.
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_key_t;

   localparam int NUM_ROUNDS = 10;
   localparam int NUM_KEYS   = 11;

   typedef enum logic [1:0] {IDLE, EXPAND, FINISH} kexp_state_t;

   localparam logic [7:0] RCON [1:NUM_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box byte substitution
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);

   assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - sequential AES-128 key schedule with an 11-entry round-key store
// Build option KEYEXP_SERIAL_SBOX_EN: one shared S-box, four cycles per round.
module aes_key_expander
   import aes_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [127:0] Key_In,
   input  logic [3:0]   Rd_Sel,
   output logic [127:0] Rd_Key,
   output logic         Busy,
   output logic         Done,
   output logic         Keys_Valid
);

   kexp_state_t state, state_nxt;
   logic [3:0]  rnd;
   logic        kv;
   aes_key_t    store [NUM_KEYS];
   aes_key_t    prev_key, next_key;
   aes_word_t   rot_word, sub_word, t_word;
   aes_word_t   w0, w1, w2, w3;
   logic [7:0]  rcon;
   logic        round_done;

   // rnd names the entry being produced; its predecessor feeds the round function
   always_comb begin
      prev_key = '0;
      rcon     = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         if (rnd == 4'(i + 1)) prev_key = store[i];
      for (int i = 1; i <= NUM_ROUNDS; i++)
         if (rnd == 4'(i)) rcon = RCON[i];
   end

   assign rot_word = {prev_key[23:0], prev_key[31:24]};
   assign t_word   = sub_word ^ {rcon, 24'h0};

   always_comb begin
      w0       = prev_key[127:96] ^ t_word;
      w1       = prev_key[95:64]  ^ w0;
      w2       = prev_key[63:32]  ^ w1;
      w3       = prev_key[31:0]   ^ w2;
      next_key = {w0, w1, w2, w3};
   end

`ifdef KEYEXP_SERIAL_SBOX_EN
   logic [1:0]  phase;
   logic [23:0] hold;
   logic [7:0]  sbox_in, sbox_out;

   always_comb begin
      sbox_in = rot_word[31:24];
      case (phase)
         2'd1:    sbox_in = rot_word[23:16];
         2'd2:    sbox_in = rot_word[15:8];
         2'd3:    sbox_in = rot_word[7:0];
         default: sbox_in = rot_word[31:24];
      endcase
   end

   aes_sbox u_sbox (.byte_val(sbox_in), .sub_val(sbox_out));

   // hold collects bytes 0..2; byte 3 goes straight from the S-box into the store
   assign sub_word   = {hold, sbox_out};
   assign round_done = (phase == 2'd3);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         phase <= 2'd0;
         hold  <= '0;
      end else if (state == EXPAND) begin
         phase <= phase + 2'd1;
         hold  <= {hold[15:0], sbox_out};
      end else begin
         phase <= 2'd0;
      end
   end
`else
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (.byte_val(rot_word[8*g +: 8]), .sub_val(sub_word[8*g +: 8]));
   end

   assign round_done = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) state_nxt = EXPAND;
         end
         EXPAND: begin
            Busy = 1'b1;
            if (round_done && rnd == 4'(NUM_ROUNDS)) state_nxt = FINISH;
         end
         FINISH: begin
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         rnd   <= '0;
         kv    <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) store[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && Start) begin
            store[0] <= Key_In;
            rnd      <= 4'd1;
            kv       <= 1'b0;
         end else if (state == EXPAND && round_done) begin
            for (int i = 1; i < NUM_KEYS; i++)
               if (rnd == 4'(i)) store[i] <= next_key;
            rnd <= rnd + 4'd1;
            if (rnd == 4'(NUM_ROUNDS)) kv <= 1'b1;
         end
      end
   end

   always_comb begin
      Rd_Key = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         if (Rd_Sel == 4'(i)) Rd_Key = store[i];
   end

   assign Keys_Valid = kv;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander
module tb_aes_key_expander;

`ifdef KEYEXP_SERIAL_SBOX_EN
   localparam int RL = 4;
`else
   localparam int RL = 1;
`endif
   localparam int DONE_CYC = 10 * RL + 1;
   localparam int PERIOD   = DONE_CYC + 1;
   localparam int HOLD     = 2 * PERIOD + 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic [3:0]   rd_sel;
   logic [127:0] rd_key;
   logic         busy, done, keys_valid;

   int tests = 0;
   int fails = 0;

   logic [7:0]   sb [256];
   logic [127:0] ref_keys [11];

   typedef struct {
      logic [127:0] key;
      logic [3:0]   sel;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   aes_key_expander dut (
      .Clk(clk), .Reset(rst), .Start(start), .Key_In(key_in), .Rd_Sel(rd_sel),
      .Rd_Key(rd_key), .Busy(busy), .Done(done), .Keys_Valid(keys_valid)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic rand_key(output logic [127:0] k);
      k = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Expand one key from a single-cycle Start; optional second Start at cycle extra_cyc
   task automatic run_expand(input logic [127:0] key, input int extra_cyc, input logic [127:0] extra_key);
      logic [127:0] junk;
      model_expand(key);
      rd_sel = 4'd3;
      @(posedge clk); #1;
      for (int c = 0; c <= DONE_CYC + 1; c++) begin
         rand_key(junk);
         if (c == 0) begin
            start = 1'b1; key_in = key;
         end else if (c == extra_cyc) begin
            start = 1'b1; key_in = extra_key;
         end else begin
            start = 1'b0; key_in = junk;
         end
         @(negedge clk);
         check1("busy", busy, (c >= 1 && c <= 10 * RL));
         check1("done", done, c == DONE_CYC);
         if (c > 0) check1("keys_valid", keys_valid, c >= DONE_CYC);
         if (c >= 3 * RL + 1) check("store3_during_expand", rd_key, ref_keys[3]);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic sweep(input string name, input logic zero_all);
      for (int s = 0; s < 16; s++) begin
         rd_sel = 4'(s);
         #1;
         if (zero_all || s > 10) check(name, rd_key, 128'h0);
         else check(name, rd_key, ref_keys[s]);
      end
   endtask

   initial begin
      logic [127:0] last_key, k, k2;
      logic [127:0] fips;
      int           waited;

      fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      vecs[0] = '{fips, 4'd0, fips};
      vecs[1] = '{fips, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{fips, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3] = '{fips, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[4] = '{128'h0, 4'd1, 128'h62636363626363636263636362636363};
      vecs[5] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[6] = '{{128{1'b1}}, 4'd1, 128'he8e9e9e917161616e8e9e9e917161616};

      build_sbox();

      rst = 1'b1; start = 1'b0; key_in = '0; rd_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("reset_busy", busy, 1'b0);
      check1("reset_done", done, 1'b0);
      check1("reset_keys_valid", keys_valid, 1'b0);
      sweep("reset_read", 1'b1);
      @(negedge clk);
      rst = 1'b0;

      last_key = 128'h1;
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].key !== last_key) begin
            run_expand(vecs[v].key, -1, '0);
            sweep("schedule_sweep", 1'b0);
            last_key = vecs[v].key;
         end
         rd_sel = vecs[v].sel;
         #1;
         check($sformatf("vector%0d", v), rd_key, vecs[v].exp);
      end

      rand_key(k2);
      run_expand(fips, 5, k2);
      sweep("ignored_start", 1'b0);

      rand_key(k);
      model_expand(k);
      @(posedge clk); #1;
      start = 1'b1; key_in = k;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check1("async_reset_busy", busy, 1'b0);
      check1("async_reset_done", done, 1'b0);
      check1("async_reset_keys_valid", keys_valid, 1'b0);
      sweep("async_reset_read", 1'b1);
      @(negedge clk);
      rst = 1'b0;
      rand_key(k);
      run_expand(k, -1, '0);
      sweep("after_reset_sweep", 1'b0);

      rand_key(k);
      model_expand(k);
      @(posedge clk); #1;
      for (int c = 0; c < HOLD; c++) begin
         start = 1'b1; key_in = k;
         @(negedge clk);
         check1("hold_busy", busy, (c % PERIOD) >= 1 && (c % PERIOD) <= 10 * RL);
         check1("hold_done", done, (c % PERIOD) == PERIOD - 1);
         if (c > 0)
            check1("hold_keys_valid", keys_valid, (c % PERIOD) == PERIOD - 1 || (c % PERIOD) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!done && waited < 2 * PERIOD) begin
         @(negedge clk);
         waited++;
      end
      check1("hold_final_done", done, 1'b1);
      @(posedge clk); #1;
      sweep("hold_sweep", 1'b0);

      for (int n = 0; n < 5; n++) begin
         rand_key(k);
         run_expand(k, -1, '0);
         sweep("random_sweep", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
